// File: rtl/axis_char_tx_if.sv
// rtl/axis_char_tx_if.sv - AXI-Stream style character stream bundle
interface axis_char_tx_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tlast;
   logic              tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_char_tx.sv
// rtl/axis_char_tx.sv - store-and-forward character framer driving an AXI-Stream master
module axis_char_tx #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_last,
   output logic              full,
   axis_char_tx_if.master    m_axis,
   output logic              ovf,
   output logic              trunc,
   output logic [15:0]       tx_frames
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SEND = 1'b1;

   localparam logic [ADDR_W:0]   CNT_FULL      = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_LAST_FREE = (ADDR_W+1)'(DEPTH-1);
   localparam logic [ADDR_W:0]   CNT_ONE       = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   CNT_ZERO      = '0;
   localparam logic [ADDR_W-1:0] PTR_ONE       = ADDR_W'(1);

   // Each entry is {last, data}
   logic [DATA_W:0]   mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count;
   logic [ADDR_W:0]   count_nxt;
   logic [ADDR_W:0]   frame_cnt;
   logic [0:0]        state;

   logic wr_acc;
   logic force_last;
   logic wr_last_eff;
   logic pop;
   logic head_last;
   logic fr_inc;
   logic fr_dec;

   // Write acceptance, forced frame termination and pop/frame bookkeeping
   always_comb begin
      wr_acc      = wr_en && !full;
      // Filling the last slot with no complete frame buffered would deadlock,
      // so the incoming byte closes the frame.
      force_last  = wr_acc && !wr_last && (count == CNT_LAST_FREE) && (frame_cnt == CNT_ZERO);
      wr_last_eff = wr_last || force_last;
      head_last   = mem[rd_ptr][DATA_W];
      pop         = (state == S_SEND) && m_axis.tready;
      fr_inc      = wr_acc && wr_last_eff;
      fr_dec      = pop && head_last;
      count_nxt   = count;
      if (wr_acc && !pop) begin
         count_nxt = count + CNT_ONE;
      end else if (!wr_acc && pop) begin
         count_nxt = count - CNT_ONE;
      end
   end

   // Stream outputs present the buffer head only while sending; head is never
   // overwritten because it is an occupied slot.
   assign m_axis.tvalid = (state == S_SEND);
   assign m_axis.tdata  = (state == S_SEND) ? mem[rd_ptr][DATA_W-1:0] : '0;
   assign m_axis.tlast  = (state == S_SEND) && head_last;

   // Buffer storage, written only on accepted pushes
   always_ff @(posedge ap_clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= {wr_last_eff, wr_data};
      end
   end

   // Pointers, occupancy, frame count, sticky flags, frame counter and FSM
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         full      <= 1'b0;
         frame_cnt <= '0;
         ovf       <= 1'b0;
         trunc     <= 1'b0;
         tx_frames <= '0;
         state     <= S_IDLE;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         count <= count_nxt;
         full  <= (count_nxt == CNT_FULL);

         if (fr_inc && !fr_dec) begin
            frame_cnt <= frame_cnt + CNT_ONE;
         end else if (!fr_inc && fr_dec) begin
            frame_cnt <= frame_cnt - CNT_ONE;
         end

         if (wr_en && full) begin
            ovf <= 1'b1;
         end
         if (force_last) begin
            trunc <= 1'b1;
         end
         if (fr_dec) begin
            tx_frames <= tx_frames + 16'd1;
         end

         case (state)
            S_IDLE: begin
               if (frame_cnt != CNT_ZERO) begin
                  state <= S_SEND;
               end
            end
            S_SEND: begin
               if (fr_dec) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_char_tx.sv
// tb/tb_axis_char_tx.sv - directed and randomized bench for axis_char_tx
module tb_axis_char_tx;

   logic        ap_clk = 1'b0;
   logic        ap_rst;
   logic        wr_en;
   logic [7:0]  wr_data;
   logic        wr_last;
   logic        full;
   logic        ovf;
   logic        trunc;
   logic [15:0] tx_frames;

   axis_char_tx_if #(.DATA_W(8)) m_axis ();

   axis_char_tx #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
      .ap_clk    (ap_clk),
      .ap_rst    (ap_rst),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .wr_last   (wr_last),
      .full      (full),
      .m_axis    (m_axis),
      .ovf       (ovf),
      .trunc     (trunc),
      .tx_frames (tx_frames)
   );

   always #5 ap_clk = ~ap_clk;

   int n_pass = 0;
   int n_total = 0;

   // reference model: buffer contents as a queue of {last,data}
   logic [8:0]  mq[$];
   int          m_frames;
   logic        m_ovf;
   logic        m_trunc;
   logic [15:0] m_txf;
   logic        mdl_on = 1'b0;
   logic        stall_prev = 1'b0;
   logic [7:0]  prev_data;
   logic        prev_last;

   // observations at the most recent negedge
   logic        obs_v;
   logic        obs_hs;
   logic [7:0]  obs_data;
   logic        obs_last;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic model_step();
      int  sz_b;
      int  fr_b;
      logic lst;
      check("ovf", ovf, m_ovf);
      check("trunc", trunc, m_trunc);
      check("tx_frames", tx_frames, m_txf);
      check("full", full, mq.size() == 16);
      if (stall_prev) begin
         check("hold_valid", obs_v, 1);
         check("hold_data", obs_data, prev_data);
         check("hold_last", obs_last, prev_last);
      end
      stall_prev = obs_v && !m_axis.tready && !ap_rst;
      prev_data  = obs_data;
      prev_last  = obs_last;
      if (ap_rst) begin
         mq.delete();
         m_frames = 0;
         m_ovf    = 1'b0;
         m_trunc  = 1'b0;
         m_txf    = '0;
         return;
      end
      sz_b = mq.size();
      fr_b = m_frames;
      if (obs_v) check("store_fwd", m_frames > 0, 1);
      if (obs_hs) begin
         if (mq.size() == 0) begin
            check("pop_empty", 1, 0);
         end else begin
            check("beat_data", obs_data, mq[0][7:0]);
            check("beat_last", obs_last, mq[0][8]);
            if (mq[0][8]) begin
               m_frames--;
               m_txf = m_txf + 16'd1;
            end
            void'(mq.pop_front());
         end
      end
      if (wr_en) begin
         if (sz_b == 16) begin
            m_ovf = 1'b1;
         end else begin
            lst = wr_last;
            if (!wr_last && sz_b == 15 && fr_b == 0) begin
               lst = 1'b1;
               m_trunc = 1'b1;
            end
            mq.push_back({lst, wr_data});
            if (lst) m_frames++;
         end
      end
   endtask

   task automatic cyc();
      @(negedge ap_clk);
      obs_v    = m_axis.tvalid;
      obs_data = m_axis.tdata;
      obs_last = m_axis.tlast;
      obs_hs   = m_axis.tvalid && m_axis.tready;
      if (mdl_on) model_step();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic do_reset();
      ap_rst = 1'b1;
      wr_en  = 1'b0;
      wr_last = 1'b0;
      m_axis.tready = 1'b0;
      cyc();
      cyc();
      ap_rst = 1'b0;
   endtask

   task automatic push(input logic [7:0] d, input logic l);
      wr_en = 1'b1;
      wr_data = d;
      wr_last = l;
      cyc();
      wr_en = 1'b0;
      wr_last = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!m_axis.tvalid && n < 50) begin
         cyc();
         n++;
      end
      if (!m_axis.tvalid) check(tag, 0, 1);
   endtask

   initial begin
      int          n;
      logic [7:0]  first_d;
      logic [7:0]  last_d;
      logic        last_l;
      logic        exp_v [4];
      logic [7:0]  exp_d [4];
      logic        exp_l [4];
      int          wr_pct;
      int          rd_pct;

      ap_rst = 1'b1;
      wr_en = 1'b0;
      wr_data = '0;
      wr_last = 1'b0;
      m_axis.tready = 1'b0;
      m_frames = 0;
      m_ovf = 1'b0;
      m_trunc = 1'b0;
      m_txf = '0;
      @(posedge ap_clk); #1;
      mdl_on = 1'b1;
      do_reset();

      check("rst_tvalid", m_axis.tvalid, 0);
      check("rst_tlast", m_axis.tlast, 0);
      check("rst_tdata", m_axis.tdata, 0);
      check("rst_full", full, 0);
      check("rst_flags", {ovf, trunc}, 0);
      check("rst_txf", tx_frames, 0);

      // T1: single-byte frame latency
      m_axis.tready = 1'b1;
      push(8'h68, 1'b1);
      check("t1_valid_k", m_axis.tvalid, 0);
      cyc();
      check("t1_valid_k1", m_axis.tvalid, 1);
      check("t1_data", m_axis.tdata, 8'h68);
      check("t1_last", m_axis.tlast, 1);
      cyc();
      check("t1_valid_after", m_axis.tvalid, 0);
      check("t1_txf", tx_frames, 1);

      // T2: backpressure holds the first beat
      do_reset();
      push(8'h68, 1'b0);
      push(8'h69, 1'b1);
      cyc();
      for (int i = 0; i < 5; i++) begin
         check("t2_hold_v", m_axis.tvalid, 1);
         check("t2_hold_d", m_axis.tdata, 8'h68);
         check("t2_hold_l", m_axis.tlast, 0);
         cyc();
      end
      m_axis.tready = 1'b1;
      check("t2_b0", {m_axis.tvalid, m_axis.tlast, m_axis.tdata}, {2'b10, 8'h68});
      cyc();
      check("t2_b1", {m_axis.tvalid, m_axis.tlast, m_axis.tdata}, {2'b11, 8'h69});
      cyc();
      check("t2_idle", m_axis.tvalid, 0);
      check("t2_txf", tx_frames, 1);

      // T3: fill without last, forced termination and overflow
      do_reset();
      for (int i = 0; i < 16; i++) push(8'h41 + 8'(i), 1'b0);
      check("t3_full", full, 1);
      check("t3_trunc", trunc, 1);
      check("t3_no_ovf", ovf, 0);
      push(8'h51, 1'b0);
      check("t3_ovf", ovf, 1);
      check("t3_full2", full, 1);
      m_axis.tready = 1'b1;
      n = 0;
      first_d = '0;
      last_d = '0;
      last_l = 1'b0;
      for (int i = 0; i < 40 && !last_l; i++) begin
         cyc();
         if (obs_hs) begin
            if (n == 0) first_d = obs_data;
            n++;
            last_d = obs_data;
            last_l = obs_last;
         end
      end
      check("t3_beats", n, 16);
      check("t3_first", first_d, 8'h41);
      check("t3_last_d", last_d, 8'h50);
      check("t3_last_l", last_l, 1);
      check("t3_txf", tx_frames, 1);

      // T4: two frames back to back with one idle cycle
      do_reset();
      push(8'h61, 1'b0);
      push(8'h62, 1'b1);
      push(8'h63, 1'b1);
      cyc();
      cyc();
      exp_v = '{1'b1, 1'b1, 1'b0, 1'b1};
      exp_d = '{8'h61, 8'h62, 8'h00, 8'h63};
      exp_l = '{1'b0, 1'b1, 1'b0, 1'b1};
      m_axis.tready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("t4_valid", obs_v, exp_v[i]);
         if (exp_v[i]) begin
            check("t4_data", obs_data, exp_d[i]);
            check("t4_last", obs_last, exp_l[i]);
         end
      end
      check("t4_txf", tx_frames, 2);

      // T5: reset mid-frame discards the remainder
      do_reset();
      push(8'h31, 1'b0);
      push(8'h32, 1'b0);
      push(8'h33, 1'b1);
      wait_valid("t5_wait");
      m_axis.tready = 1'b1;
      cyc();
      ap_rst = 1'b1;
      cyc();
      ap_rst = 1'b0;
      check("t5_valid", m_axis.tvalid, 0);
      check("t5_full", full, 0);
      check("t5_txf", tx_frames, 0);
      check("t5_data", m_axis.tdata, 0);
      n = 0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         if (obs_v) n++;
      end
      check("t5_silent", n, 0);
      push(8'h7A, 1'b1);
      n = 0;
      last_d = '0;
      for (int i = 0; i < 10 && n == 0; i++) begin
         cyc();
         if (obs_hs) begin
            n++;
            last_d = obs_data;
            last_l = obs_last;
         end
      end
      check("t5_new_beat", n, 1);
      check("t5_new_data", last_d, 8'h7A);
      check("t5_new_txf", tx_frames, 1);

      // T6: push a last byte during the previous frame's tlast handshake
      do_reset();
      m_axis.tready = 1'b1;
      push(8'h70, 1'b1);
      cyc();
      check("t6_v1", m_axis.tvalid, 1);
      push(8'h71, 1'b1);
      check("t6_gap", m_axis.tvalid, 0);
      cyc();
      check("t6_v2", m_axis.tvalid, 1);
      check("t6_d2", m_axis.tdata, 8'h71);
      cyc();
      check("t6_txf", tx_frames, 2);

      // Randomized traffic against the reference model
      do_reset();
      for (int seg = 0; seg < 6; seg++) begin
         wr_pct = $urandom_range(10, 95);
         rd_pct = $urandom_range(0, 100);
         for (int i = 0; i < 300; i++) begin
            wr_en = ($urandom_range(0, 99) < wr_pct);
            wr_data = 8'($urandom);
            wr_last = ($urandom_range(0, 5) == 0);
            m_axis.tready = ($urandom_range(0, 99) < rd_pct);
            cyc();
         end
      end
      wr_en = 1'b0;
      wr_last = 1'b0;
      m_axis.tready = 1'b0;
      cyc();
      if (mq.size() > 0 && mq.size() < 16 && !mq[mq.size()-1][8]) push(8'h2E, 1'b1);
      m_axis.tready = 1'b1;
      for (int i = 0; i < 100 && mq.size() > 0; i++) cyc();
      check("rand_drain", mq.size(), 0);
      cyc();
      check("rand_idle", m_axis.tvalid, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
